// File: rtl/bcid_buf_pkg.sv
// Shared types and the BCID modulo-add helper used by the capture logic
// and by the testbench reference model.
package bcid_buf_pkg;

    localparam int unsigned BCID_MAX_DEFAULT   = 32'd3564;
    localparam int unsigned BCID_WIDTH_DEFAULT = 32'd12;

    typedef logic [BCID_WIDTH_DEFAULT-1:0] bcid_t;

    // Operands are already < max, so one conditional subtract is enough.
    function automatic int unsigned bcid_add_mod(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned max);
        int unsigned sum;
        sum = a + b;
        if (sum >= max) begin
            sum = sum - max;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/bcid_buf_mem.sv
// Simple dual-port register array: one write port, one registered read port.
// The array itself carries no reset; only the read register does.
module bcid_buf_mem #(
    parameter int unsigned ADDRWIDTH = 7,
    parameter int unsigned DATAWIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDRWIDTH-1:0] wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    output logic [DATAWIDTH-1:0] rd_data
);

    logic [DATAWIDTH-1:0] mem_r [2**ADDRWIDTH];
    logic [DATAWIDTH-1:0] rd_data_r;

    // Write port; a same-edge read of the same address returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, holds its value between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {DATAWIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/bcid_l1a_buffer.sv
// L1A-triggered BCID buffer: captures BCID+offset on each trigger, delays it
// through a short pipe and stores it in a circular FIFO read by the frame builder.
module bcid_l1a_buffer
    import bcid_buf_pkg::*;
#(
    parameter int unsigned BCID_WIDTH = 12,
    parameter int unsigned ADDRWIDTH  = 7,
    parameter int unsigned BCID_MAX   = BCID_MAX_DEFAULT,
    parameter int unsigned L1A_DELAY  = 2,
    parameter int unsigned DROPW      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BCID_WIDTH-1:0] inBCID,
    input  logic [BCID_WIDTH-1:0] bcidOffset,
    input  logic                  L1A,
    input  logic                  rdEn,
    input  logic                  clrFlags,
    output logic [BCID_WIDTH-1:0] outBCID,
    output logic                  outValid,
    output logic                  empty,
    output logic                  full,
    output logic [ADDRWIDTH:0]    occupancy,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DROPW-1:0]      dropCount
);

    localparam int unsigned OW    = ADDRWIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDRWIDTH;

    logic [L1A_DELAY-1:0]  pipe_valid_r;
    logic [BCID_WIDTH-1:0] pipe_data_r [L1A_DELAY];
    logic [ADDRWIDTH-1:0]  wr_ptr_r, rd_ptr_r;
    logic [OW-1:0]         occ_r, occ_next_s;
    logic                  full_r, empty_r, out_valid_r, overflow_r, underflow_r;
    logic [DROPW-1:0]      drop_count_r;
    int unsigned           sum_s;
    logic [BCID_WIDTH-1:0] cap_s;
    logic                  wr_req_s, pop_s, wr_ok_s, drop_s, under_s;

    // Capture value and write/pop/drop decisions for this edge.
    always_comb begin
        sum_s      = bcid_add_mod(32'(inBCID), 32'(bcidOffset), BCID_MAX);
        cap_s      = sum_s[BCID_WIDTH-1:0];
        wr_req_s   = pipe_valid_r[L1A_DELAY-1];
        pop_s      = rdEn & ~empty_r;
        under_s    = rdEn & empty_r;
        wr_ok_s    = wr_req_s & (~full_r | pop_s);
        drop_s     = wr_req_s & ~wr_ok_s;
        occ_next_s = occ_r + OW'(wr_ok_s) - OW'(pop_s);
    end

    // Trigger valid pipe; reset discards in-flight triggers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_r <= {L1A_DELAY{1'b0}};
        end else begin
            pipe_valid_r <= {pipe_valid_r[L1A_DELAY-1:0], L1A} >> 0;
        end
    end

    // Data pipe follows the valid pipe; contents are don't-care when invalid.
    always_ff @(posedge clk) begin
        pipe_data_r[0] <= cap_s;
        for (int i = 1; i < int'(L1A_DELAY); i++) begin
            pipe_data_r[i] <= pipe_data_r[i-1];
        end
    end

    // Pointers, occupancy and the full/empty flags derived from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {ADDRWIDTH{1'b0}};
            rd_ptr_r    <= {ADDRWIDTH{1'b0}};
            occ_r       <= {OW{1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_r + ADDRWIDTH'(wr_ok_s);
            rd_ptr_r    <= rd_ptr_r + ADDRWIDTH'(pop_s);
            occ_r       <= occ_next_s;
            full_r      <= (occ_next_s == OW'(DEPTH));
            empty_r     <= (occ_next_s == {OW{1'b0}});
            out_valid_r <= pop_s;
        end
    end

    // Sticky error flags and saturating drop counter; a same-edge event beats clrFlags.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
            drop_count_r <= {DROPW{1'b0}};
        end else if (clrFlags) begin
            overflow_r   <= drop_s;
            underflow_r  <= under_s;
            drop_count_r <= DROPW'(drop_s);
        end else begin
            overflow_r   <= overflow_r | drop_s;
            underflow_r  <= underflow_r | under_s;
            if (drop_s && (drop_count_r != {DROPW{1'b1}})) begin
                drop_count_r <= drop_count_r + {{(DROPW-1){1'b0}}, 1'b1};
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    bcid_buf_mem #(
        .ADDRWIDTH(ADDRWIDTH),
        .DATAWIDTH(BCID_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok_s),
        .wr_addr (wr_ptr_r),
        .wr_data (pipe_data_r[L1A_DELAY-1]),
        .rd_en   (pop_s),
        .rd_addr (rd_ptr_r),
        .rd_data (outBCID)
    );

    assign outValid  = out_valid_r;
    assign empty     = empty_r;
    assign full      = full_r;
    assign occupancy = occ_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign dropCount = drop_count_r;

endmodule

// File: tb/tb_bcid_l1a_buffer.sv
// Directed self-checking bench for bcid_l1a_buffer with default parameters.
module tb_bcid_l1a_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] inBCID;
    logic [11:0] bcidOffset;
    logic        L1A;
    logic        rdEn;
    logic        clrFlags;
    logic [11:0] outBCID;
    logic        outValid;
    logic        empty;
    logic        full;
    logic [7:0]  occupancy;
    logic        overflow;
    logic        underflow;
    logic [7:0]  dropCount;

    int checks = 0;
    int errors = 0;

    bcid_l1a_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .inBCID     (inBCID),
        .bcidOffset (bcidOffset),
        .L1A        (L1A),
        .rdEn       (rdEn),
        .clrFlags   (clrFlags),
        .outBCID    (outBCID),
        .outValid   (outValid),
        .empty      (empty),
        .full       (full),
        .occupancy  (occupancy),
        .overflow   (overflow),
        .underflow  (underflow),
        .dropCount  (dropCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; L1A = 1'b0; rdEn = 1'b0; clrFlags = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        inBCID = 12'd0; bcidOffset = 12'd0;
        do_reset();
        checks++;
        if ({occupancy, empty, full, outValid, outBCID, overflow, underflow, dropCount} !==
            {8'd0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: occ=%0d empty=%0d full=%0d vld=%0d out=%0d ovf=%0d unf=%0d drop=%0d required 0 1 0 0 0 0 0 0",
                     occupancy, empty, full, outValid, outBCID, overflow, underflow, dropCount);
        end
    endtask

    task automatic test_basic();
        do_reset();
        inBCID = 12'd100; bcidOffset = 12'd5; L1A = 1'b1;
        tick();
        L1A = 1'b0;
        tick();
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty_before_write: got %0d required 1", empty); end
        tick();
        checks++;
        if (empty !== 1'b0 || occupancy !== 8'd1) begin
            errors++; $display("FAIL basic_written: empty=%0d occ=%0d required 0 1", empty, occupancy);
        end
        tick();
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        checks++;
        if (outValid !== 1'b1 || outBCID !== 12'd105) begin
            errors++; $display("FAIL basic_pop: vld=%0d out=%0d required 1 105", outValid, outBCID);
        end
        tick();
        checks++;
        if (outValid !== 1'b0 || outBCID !== 12'd105 || empty !== 1'b1) begin
            errors++; $display("FAIL basic_after_pop: vld=%0d out=%0d empty=%0d required 0 105 1", outValid, outBCID, empty);
        end
    endtask

    task automatic test_offset_wrap();
        do_reset();
        bcidOffset = 12'd10;
        inBCID = 12'd3560; L1A = 1'b1;
        tick();
        inBCID = 12'd3553;
        tick();
        L1A = 1'b0;
        tick(); tick();
        rdEn = 1'b1;
        tick();
        checks++;
        if (outBCID !== 12'd6) begin errors++; $display("FAIL wrap_3560p10: got %0d required 6", outBCID); end
        tick();
        rdEn = 1'b0;
        checks++;
        if (outBCID !== 12'd3563) begin errors++; $display("FAIL wrap_3553p10: got %0d required 3563", outBCID); end
    endtask

    // Fills, overflows, then exercises write+pop on a full FIFO and clrFlags.
    task automatic test_fill_full();
        do_reset();
        bcidOffset = 12'd0;
        for (int i = 0; i < 131; i++) begin
            inBCID = (i < 128) ? 12'(i * 3) : 12'(1000 + i);
            L1A = 1'b1;
            tick();
        end
        L1A = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (full !== 1'b1 || occupancy !== 8'd128 || overflow !== 1'b1 || dropCount !== 8'd3) begin
            errors++; $display("FAIL fill_overflow: full=%0d occ=%0d ovf=%0d drop=%0d required 1 128 1 3",
                               full, occupancy, overflow, dropCount);
        end
        inBCID = 12'd2000; L1A = 1'b1;
        tick();
        L1A = 1'b0;
        tick();
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        checks++;
        if (outValid !== 1'b1 || outBCID !== 12'd0 || occupancy !== 8'd128 || full !== 1'b1 || dropCount !== 8'd3) begin
            errors++; $display("FAIL full_write_pop: vld=%0d out=%0d occ=%0d full=%0d drop=%0d required 1 0 128 1 3",
                               outValid, outBCID, occupancy, full, dropCount);
        end
        clrFlags = 1'b1;
        tick();
        clrFlags = 1'b0;
        checks++;
        if (overflow !== 1'b0 || dropCount !== 8'd0) begin
            errors++; $display("FAIL clr_flags: ovf=%0d drop=%0d required 0 0", overflow, dropCount);
        end
        rdEn = 1'b1;
        for (int i = 1; i < 129; i++) begin
            tick();
            checks++;
            if (outValid !== 1'b1 || outBCID !== ((i < 128) ? 12'(i * 3) : 12'd2000)) begin
                errors++; $display("FAIL read_order[%0d]: vld=%0d out=%0d required 1 %0d",
                                   i, outValid, outBCID, (i < 128) ? i * 3 : 2000);
            end
        end
        rdEn = 1'b0;
        tick();
        checks++;
        if (empty !== 1'b1 || occupancy !== 8'd0 || underflow !== 1'b0) begin
            errors++; $display("FAIL drained: empty=%0d occ=%0d unf=%0d required 1 0 0", empty, occupancy, underflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        checks++;
        if (underflow !== 1'b1 || outValid !== 1'b0) begin
            errors++; $display("FAIL underflow_empty_read: unf=%0d vld=%0d required 1 0", underflow, outValid);
        end
        clrFlags = 1'b1;
        tick();
        clrFlags = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %0d required 0", underflow); end
        inBCID = 12'd50; bcidOffset = 12'd0; L1A = 1'b1;
        tick();
        L1A = 1'b0;
        tick();
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        checks++;
        if (occupancy !== 8'd1 || underflow !== 1'b1 || outValid !== 1'b0) begin
            errors++; $display("FAIL empty_write_pop: occ=%0d unf=%0d vld=%0d required 1 1 0", occupancy, underflow, outValid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bcidOffset = 12'd1;
        for (int i = 0; i < 40; i++) begin
            inBCID = 12'(i); L1A = 1'b1;
            tick();
        end
        L1A = 1'b0;
        tick(); tick();
        checks++;
        if (occupancy !== 8'd40) begin errors++; $display("FAIL mid_fill: occ=%0d required 40", occupancy); end
        L1A = 1'b1;
        tick(); tick();
        L1A = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (occupancy !== 8'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL mid_reset: occ=%0d empty=%0d required 0 1", occupancy, empty);
        end
        tick(); tick(); tick();
        checks++;
        if (occupancy !== 8'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL mid_reset_no_late_write: occ=%0d empty=%0d required 0 1", occupancy, empty);
        end
    endtask

    initial begin
        reset = 1'b1; L1A = 1'b0; rdEn = 1'b0; clrFlags = 1'b0;
        inBCID = 12'd0; bcidOffset = 12'd0;
        test_reset();
        test_basic();
        test_offset_wrap();
        test_fill_full();
        test_underflow();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
